// File: rtl/ps2_key_decoder_if.sv
// Key event bus from the PS/2 decoder to the game control logic.
// The decoder drives it through the master modport; the consumer reads it through slave.
interface ps2_key_decoder_if;
    logic [7:0] key_code;
    logic       key_break;
    logic       key_ext;
    logic       key_valid;
    logic       frame_err;

    modport master (
        output key_code,
        output key_break,
        output key_ext,
        output key_valid,
        output frame_err
    );

    modport slave (
        input key_code,
        input key_break,
        input key_ext,
        input key_valid,
        input frame_err
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver.
// Synchronizes the keyboard clock and data lines and deserializes 11-bit frames
// (start, 8 data LSB first, odd parity, stop). It folds the E0 and F0 prefixes
// into flags and emits one key event per press or release.
// A frame that stalls mid-way for TIMEOUT_CYC cycles is abandoned with frame_err.
module ps2_key_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ps2_clk,
    input  logic                      ps2_data,
    ps2_key_decoder_if.master         key_if
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Synchronizer chains. Index 0 samples the pin; the top index feeds the decoder.
    logic [SYNC_STAGES-1:0] clk_sync_reg;
    logic [SYNC_STAGES-1:0] data_sync_reg;
    logic                   sync_clk_prev_reg;

    logic sync_clk;
    logic sync_data;
    logic fall;

    state_t           state_reg;
    logic [7:0]       shift_reg;
    logic [2:0]       bit_cnt_reg;
    logic             parity_reg;
    logic [CNT_W-1:0] timeout_reg;
    logic             pend_break_reg;
    logic             pend_ext_reg;

    logic [7:0]       key_code_reg;
    logic             key_break_reg;
    logic             key_ext_reg;
    logic             key_valid_reg;
    logic             frame_err_reg;

    // Frame check at the stop bit: odd parity over data and parity, and stop must be high.
    logic frame_bad;

    // Shift both PS/2 lines through the synchronizer; they idle high, so the chain resets to 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_reg      <= '1;
            data_sync_reg     <= '1;
            sync_clk_prev_reg <= 1'b1;
        end else begin
            if (SYNC_STAGES > 1) begin
                clk_sync_reg  <= {clk_sync_reg[SYNC_STAGES-2:0], ps2_clk};
                data_sync_reg <= {data_sync_reg[SYNC_STAGES-2:0], ps2_data};
            end else begin
                clk_sync_reg  <= {SYNC_STAGES{ps2_clk}};
                data_sync_reg <= {SYNC_STAGES{ps2_data}};
            end
            sync_clk_prev_reg <= clk_sync_reg[SYNC_STAGES-1];
        end
    end

    assign sync_clk  = clk_sync_reg[SYNC_STAGES-1];
    assign sync_data = data_sync_reg[SYNC_STAGES-1];
    assign fall      = sync_clk_prev_reg & ~sync_clk;
    assign frame_bad = ~(^{shift_reg, parity_reg}) | ~sync_data;

    // Frame FSM, timeout watchdog, prefix tracking and registered event outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            shift_reg      <= '0;
            bit_cnt_reg    <= '0;
            parity_reg     <= 1'b0;
            timeout_reg    <= '0;
            pend_break_reg <= 1'b0;
            pend_ext_reg   <= 1'b0;
            key_code_reg   <= '0;
            key_break_reg  <= 1'b0;
            key_ext_reg    <= 1'b0;
            key_valid_reg  <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            key_valid_reg <= 1'b0;
            frame_err_reg <= 1'b0;

            if (state_reg == IDLE) begin
                timeout_reg <= '0;
                // A high data line on a falling clock is not a start bit; ignore it.
                if (fall && !sync_data) begin
                    state_reg   <= DATA;
                    bit_cnt_reg <= '0;
                end
            end else if (fall) begin
                // A falling edge always beats the watchdog, even on its last cycle.
                timeout_reg <= '0;
                case (state_reg)
                    DATA: begin
                        shift_reg[bit_cnt_reg] <= sync_data;
                        if (bit_cnt_reg == 3'd7) begin
                            state_reg <= PARITY;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        end
                    end
                    PARITY: begin
                        parity_reg <= sync_data;
                        state_reg  <= STOP;
                    end
                    STOP: begin
                        state_reg   <= IDLE;
                        bit_cnt_reg <= '0;
                        if (frame_bad) begin
                            frame_err_reg  <= 1'b1;
                            pend_break_reg <= 1'b0;
                            pend_ext_reg   <= 1'b0;
                        end else if (shift_reg == 8'hE0) begin
                            pend_ext_reg <= 1'b1;
                        end else if (shift_reg == 8'hF0) begin
                            pend_break_reg <= 1'b1;
                        end else begin
                            key_code_reg   <= shift_reg;
                            key_break_reg  <= pend_break_reg;
                            key_ext_reg    <= pend_ext_reg;
                            key_valid_reg  <= 1'b1;
                            pend_break_reg <= 1'b0;
                            pend_ext_reg   <= 1'b0;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end else if (timeout_reg == TIMEOUT_LAST) begin
                // Keyboard went quiet mid-frame: drop the frame and any prefix state.
                state_reg      <= IDLE;
                bit_cnt_reg    <= '0;
                timeout_reg    <= '0;
                frame_err_reg  <= 1'b1;
                pend_break_reg <= 1'b0;
                pend_ext_reg   <= 1'b0;
            end else begin
                timeout_reg <= timeout_reg + CNT_W'(1);
            end
        end
    end

    assign key_if.key_code  = key_code_reg;
    assign key_if.key_break = key_break_reg;
    assign key_if.key_ext   = key_ext_reg;
    assign key_if.key_valid = key_valid_reg;
    assign key_if.frame_err = frame_err_reg;

endmodule
